// File: rtl/shared_pkg.sv
// Shared constants, occupancy encoding and pointer helper for the stream adapter.
package shared_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_PKT_LEN    = 4;
  localparam int BUF_DEPTH      = 3;

  localparam logic [1:0] LAST_PTR = 2'(BUF_DEPTH - 1);
  localparam logic [1:0] FULL_OCC = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_PART  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  // Collapse the raw occupancy count into the three externally meaningful states.
  function automatic occ_state_e occ_state_of(input logic [1:0] occ);
    if (occ == 2'd0)          return OCC_EMPTY;
    else if (occ == FULL_OCC) return OCC_FULL;
    else                      return OCC_PART;
  endfunction

  // Circular pointer advance; the buffer depth is not a power of two.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_stream_adapter_buf.sv
// stream_buf: three-entry circular skid buffer between FIFO read data and the stream.
module stream_buf
  import shared_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [1:0]            occ,
  output logic [1:0]            occ_state
);

  logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;

  assign pop_data  = mem[rd_ptr];
  assign occ_state = occ_state_of(occ);

  // Storage and write pointer; entries are cleared so the stream data reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 2'd0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= ptr_inc(wr_ptr);
    end
  end

  // Read pointer and occupancy; simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter: turns a 1-cycle-latency FIFO read port into a valid/ready
// packet stream with last-beat marking and a completed-packet counter.
module fifo_stream_adapter
  import shared_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PKT_LEN    = DEF_PKT_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [15:0]           pkt_count
);

  localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

  logic       inflight;
  logic [1:0] occ;
  logic [1:0] occ_state;
  logic [7:0] beat;
  logic       handshake;

  // A read is only issued when the buffer can absorb it plus any word already
  // returning, so pushes never overflow. m_ready is deliberately not used here.
  assign fifo_rd_en = rst_n && !fifo_empty && (occ_state != OCC_FULL) &&
                      (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

  assign m_valid   = (occ != 2'd0);
  assign handshake = m_valid && m_ready;
  assign m_last    = m_valid && (beat == LAST_BEAT);

  stream_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (handshake),
    .pop_data  (m_data),
    .occ       (occ),
    .occ_state (occ_state)
  );

  // Track the read issued last cycle; its data is on fifo_data_out now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  // Beat position within the packet, advancing on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         beat <= 8'd0;
    else if (handshake) beat <= (beat == LAST_BEAT) ? 8'd0 : beat + 8'd1;
  end

  // Completed packets; naturally wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   pkt_count <= 16'd0;
    else if (handshake && m_last) pkt_count <= pkt_count + 16'd1;
  end

endmodule
